// File: rtl/apu_req_dispatch_if.sv
// Core-side and unit-side bus bundle of the APU request dispatcher.
// slave: the dispatcher's view. master: the cores + FP unit environment view.
interface apu_req_dispatch_if #(
  parameter int NB_CORES = 8,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NUSFLAGS = 5,
  parameter int NDSFLAGS = 15
);
  // core side
  logic [NB_CORES-1:0]                  core_req;
  logic [NB_CORES-1:0]                  core_gnt;
  logic [NB_CORES-1:0][NARGS-1:0][31:0] core_operands;
  logic [NB_CORES-1:0][WOP-1:0]         core_op;
  logic [NB_CORES-1:0][NDSFLAGS-1:0]    core_flags;
  logic [NB_CORES-1:0]                  core_rvalid;
  logic [31:0]                          core_result;
  logic [NUSFLAGS-1:0]                  core_rflags;

  // unit side
  logic                                 unit_req;
  logic                                 unit_gnt;
  logic [NARGS-1:0][31:0]               unit_operands;
  logic [WOP-1:0]                       unit_op;
  logic [NDSFLAGS-1:0]                  unit_flags;
  logic                                 unit_rvalid;
  logic [31:0]                          unit_result;
  logic [NUSFLAGS-1:0]                  unit_rflags;

  modport slave (
    input  core_req, core_operands, core_op, core_flags,
    input  unit_gnt, unit_rvalid, unit_result, unit_rflags,
    output core_gnt, core_rvalid, core_result, core_rflags,
    output unit_req, unit_operands, unit_op, unit_flags
  );

  modport master (
    output core_req, core_operands, core_op, core_flags,
    output unit_gnt, unit_rvalid, unit_result, unit_rflags,
    input  core_gnt, core_rvalid, core_result, core_rflags,
    input  unit_req, unit_operands, unit_op, unit_flags
  );
endinterface

// File: rtl/apu_req_dispatch.sv
// Round-robin dispatcher from NB_CORES APU ports onto one shared in-order FP unit.
// An order FIFO remembers which core issued each op so results are steered back,
// one registered stage after the unit returns them. In-flight ops are capped at
// MAX_OUTSTANDING; a result with nothing in flight raises a sticky error.
module apu_req_dispatch #(
  parameter int NB_CORES        = 8,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NUSFLAGS        = 5,
  parameter int NDSFLAGS        = 15,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  apu_req_dispatch_if.slave                  bus,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int IDW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;

  // state
  logic [IDW-1:0]                        rr_q, rr_d;
  logic [MAX_OUTSTANDING-1:0][IDW-1:0]   ord_q, ord_d;
  logic [PW-1:0]                         wptr_q, wptr_d;
  logic [PW-1:0]                         rptr_q, rptr_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [NB_CORES-1:0]                   rvalid_q, rvalid_d;
  logic [31:0]                           result_q, result_d;
  logic [NUSFLAGS-1:0]                   rflags_q, rflags_d;
  logic                                  err_q, err_d;

  // arbitration / handshake
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           found;
  logic           any_req;
  logic           fifo_full;
  logic           fifo_empty;
  logic           unit_req;
  logic           hs;
  logic           pop;

  assign any_req    = |bus.core_req;
  assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  // Full blocks issue even if a pop lands this cycle: keeps push-when-full impossible.
  assign unit_req   = any_req && !fifo_full;
  assign hs         = unit_req && bus.unit_gnt;
  assign pop        = bus.unit_rvalid && !fifo_empty;

  // Round-robin pick: first requester at or after rr_q, wrapping.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      cand = IDW'((32'(rr_q) + 32'(i)) % NB_CORES);
      if (!found && bus.core_req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Unit-side payload mux and single-hot grant back to the winner.
  always_comb begin
    bus.unit_req      = unit_req;
    bus.core_gnt      = '0;
    bus.unit_operands = '0;
    bus.unit_op       = '0;
    bus.unit_flags    = '0;
    if (hs) bus.core_gnt[win] = 1'b1;
    if (unit_req) begin
      bus.unit_operands = bus.core_operands[win];
      bus.unit_op       = bus.core_op[win];
      bus.unit_flags    = bus.core_flags[win];
    end
  end

  // Order FIFO and round-robin pointer next state.
  always_comb begin
    ord_d  = ord_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    rr_d   = rr_q;
    if (hs) begin
      ord_d[wptr_q] = win;
      wptr_d        = wptr_q + 1'b1;
      rr_d          = (win == IDW'(NB_CORES - 1)) ? '0 : win + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Response steering: head of FIFO picks the core; buses hold when idle.
  always_comb begin
    rvalid_d = '0;
    result_d = result_q;
    rflags_d = rflags_q;
    if (pop) begin
      rvalid_d[ord_q[rptr_q]] = 1'b1;
      result_d                = bus.unit_result;
      rflags_d                = bus.unit_rflags;
    end
  end

  // A result with nothing in flight (and nothing being issued) is a protocol error.
  always_comb begin
    err_d = err_q | (bus.unit_rvalid && fifo_empty && !hs);
  end

  // State registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q     <= '0;
      ord_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      result_q <= '0;
      rflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      ord_q    <= ord_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
      err_q    <= err_d;
    end
  end

  assign bus.core_rvalid = rvalid_q;
  assign bus.core_result = result_q;
  assign bus.core_rflags = rflags_q;
  assign outstanding_o   = cnt_q;
  assign err_o           = err_q;

endmodule
